uart_dbg_responder: RTL and testbench
=====================================

UART_DBG_RESPONDER -- requirements
Module: uart_dbg_responder

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 100000, meaning clk_i cycles of receive inactivity allowed mid-command.
REQ-002 SHALL have parameter AddrWidth, default 32, meaning bus address width.
REQ-003 SHALL have port clk_i  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have ports rx_data_i  in  8, rx_valid_i  in  1, rx_ready_o  out  1: received-byte stream from the UART receiver (valid/ready).
REQ-006 SHALL have ports tx_data_o  out  8, tx_valid_o  out  1, tx_ready_i  in  1: byte stream to the UART transmitter.
REQ-007 SHALL have OBI manager ports obi_req_o out 1, obi_gnt_i in 1, obi_addr_o out AddrWidth, obi_we_o out 1, obi_be_o out 4, obi_wdata_o out 32, obi_rvalid_i in 1, obi_rdata_i in 32, obi_err_i in 1.
REQ-008 SHALL have ports exec_addr_o  out  AddrWidth (entry point) and exec_valid_o  out  1 (one-cycle pulse).
REQ-009 SHALL have port eoc_i  in  1: end-of-code event pulse from the SoC control block.

Function
REQ-010 Bytes SHALL be consumed only when rx_valid_i & rx_ready_o; rx_ready_o high only in IDLE, ADDR, LEN, WDATA.
REQ-011 Commands: 0x11 READ = cmd, 4 addr bytes LSB-first, 1 count byte; 0x12 WRITE = same header then count*4 data bytes LSB-first; 0x13 EXEC = cmd, 4 addr bytes.
REQ-012 Count byte 0 SHALL mean 256 words; addr[1:0] SHALL be ignored (forced 0); address SHALL increment by 4 per word, wrapping modulo 2^AddrWidth.
REQ-013 Any other byte in IDLE SHALL be discarded with no response.
REQ-014 States: IDLE, ADDR, LEN, WDATA, BUS_REQ, BUS_WAIT, TX_DATA, TX_RESP; one outstanding OBI transaction at most.
REQ-015 obi_req_o and address/we/be/wdata SHALL stay stable from assertion until obi_gnt_i; req drops the cycle after grant; obi_be_o = 4'hF always.
REQ-016 WRITE: each word SHALL issue on the bus once its 4th byte is received; reception of the next word resumes after its rvalid.
REQ-017 READ: each word's rvalid data SHALL be sent as 4 tx bytes LSB-first before the next bus request.
REQ-018 tx_data_o/tx_valid_o SHALL hold until tx_ready_i; tx_valid_o SHALL never drop without a handshake.
REQ-019 After the last word, TX_RESP SHALL send 0x06 (ACK), or 0x15 (NAK) if obi_err_i was high with any rvalid of the command; read bytes for an erroring word SHALL be 0x00.
REQ-020 EXEC: after the 4th addr byte, exec_addr_o SHALL load the word-aligned address, exec_valid_o SHALL pulse one cycle, then 0x06 is sent.
REQ-021 eoc_i SHALL set a sticky pending flag; 0x14 (EOC) SHALL be sent from IDLE only, before accepting a new command byte; a second eoc_i while pending is absorbed.
REQ-022 eoc_i arriving mid-command SHALL not corrupt the running command; EOC follows its ACK/NAK.

Reset
REQ-023 On rst_ni low all outputs SHALL be 0 (rx_ready_o, tx_valid_o, tx_data_o, obi_*, exec_*), state IDLE, counters and EOC flag cleared, asynchronously.
REQ-024 Reset mid-bus-transaction SHALL abandon it; a late obi_rvalid_i after reset in IDLE SHALL be ignored.

Configuration
REQ-025 Macro UART_DBG_TIMEOUT_EN defined: in ADDR, LEN or WDATA, TimeoutCycles consecutive cycles without a received byte SHALL return to IDLE, sending nothing; counter restarts on each byte.
REQ-026 UART_DBG_TIMEOUT_EN undefined: no timeout counter; the block waits indefinitely for bytes.

Verification
REQ-027 WRITE 12 00 00 00 10 02 + 78 56 34 12 EF BE AD DE -> writes 0x12345678 @0x10000000, 0xDEADBEEF @0x10000004, tx 0x06.
REQ-028 READ 11 04 00 00 10 01 with rdata 0xDEADBEEF -> tx EF BE AD DE 06; addr 0x10000004.
REQ-029 READ with obi_err_i on rvalid -> tx 00 00 00 00 15.
REQ-030 EXEC 13 80 00 00 10 -> exec_addr_o 0x10000080, exec_valid_o one cycle, tx 06; eoc_i pulse during it -> tx 06 then 14.
REQ-031 tx_ready_i held low 20 cycles mid-read -> tx_data_o/tx_valid_o stable, no byte lost; obi_gnt_i delayed 5 cycles -> request stable.
REQ-032 With UART_DBG_TIMEOUT_EN, TimeoutCycles=50: send 11 00 then stall 50 cycles -> IDLE, no tx; next 11 command executes normally.

Source files
------------

// File: rtl/uart_dbg_responder.sv
// UART debug command responder: READ/WRITE/EXEC over an OBI manager port, plus EOC notification.
// Optional receive timeout when UART_DBG_TIMEOUT_EN is defined.
module uart_dbg_responder #(
    parameter int unsigned TimeoutCycles = 100000,
    parameter int unsigned AddrWidth     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_valid_i,
    output logic                 rx_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic                 obi_req_o,
    input  logic                 obi_gnt_i,
    output logic [AddrWidth-1:0] obi_addr_o,
    output logic                 obi_we_o,
    output logic [3:0]           obi_be_o,
    output logic [31:0]          obi_wdata_o,
    input  logic                 obi_rvalid_i,
    input  logic [31:0]          obi_rdata_i,
    input  logic                 obi_err_i,
    output logic [AddrWidth-1:0] exec_addr_o,
    output logic                 exec_valid_o,
    input  logic                 eoc_i
);

    localparam logic [7:0] CmdRead  = 8'h11;
    localparam logic [7:0] CmdWrite = 8'h12;
    localparam logic [7:0] CmdExec  = 8'h13;
    localparam logic [7:0] ByteAck  = 8'h06;
    localparam logic [7:0] ByteNak  = 8'h15;
    localparam logic [7:0] ByteEoc  = 8'h14;

    if (TimeoutCycles == 0) begin : g_bad_timeout
        $error("TimeoutCycles must be nonzero");
    end

    typedef enum logic [2:0] {
        IDLE, ADDR, LEN, WDATA, BUS_REQ, BUS_WAIT, TX_DATA, TX_RESP
    } state_e;

    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_EXEC} op_e;

    state_e               state_q;
    op_e                  op_q;
    logic [1:0]           byte_cnt_q;
    logic [8:0]           words_left_q;
    logic [31:0]          shift_q;
    logic [AddrWidth-1:0] addr_q;
    logic                 err_q;
    logic                 eoc_pend_q;

    logic                 rx_hs;
    logic                 tx_hs;
    logic                 eoc_set;
    logic [31:0]          shift_in;
    logic [AddrWidth-1:0] addr_trunc;
    logic [AddrWidth-1:0] addr_in;

    assign rx_hs      = rx_valid_i & rx_ready_o;
    assign tx_hs      = tx_valid_o & tx_ready_i;
    assign eoc_set    = eoc_pend_q | eoc_i;
    // One shift register serves address bytes, write data and outgoing read data.
    assign shift_in   = {rx_data_i, shift_q[31:8]};
    assign addr_trunc = AddrWidth'(shift_in);
    assign addr_in    = addr_trunc & ~AddrWidth'(3);

    function automatic logic [7:0] resp_byte(input logic err);
        return err ? ByteNak : ByteAck;
    endfunction

`ifdef UART_DBG_TIMEOUT_EN
    localparam int unsigned ToW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    logic [ToW-1:0] to_cnt_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            op_q         <= OP_READ;
            byte_cnt_q   <= 2'd0;
            words_left_q <= 9'd0;
            shift_q      <= 32'd0;
            addr_q       <= '0;
            err_q        <= 1'b0;
            eoc_pend_q   <= 1'b0;
            rx_ready_o   <= 1'b0;
            tx_data_o    <= 8'd0;
            tx_valid_o   <= 1'b0;
            obi_req_o    <= 1'b0;
            obi_addr_o   <= '0;
            obi_we_o     <= 1'b0;
            obi_be_o     <= 4'h0;
            obi_wdata_o  <= 32'd0;
            exec_addr_o  <= '0;
            exec_valid_o <= 1'b0;
`ifdef UART_DBG_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            exec_valid_o <= 1'b0;
            obi_be_o     <= 4'hF;
            eoc_pend_q   <= eoc_set;

            case (state_q)
                IDLE: begin
                    if (rx_hs) begin
                        byte_cnt_q <= 2'd0;
                        err_q      <= 1'b0;
                        case (rx_data_i)
                            CmdRead:  begin op_q <= OP_READ;  state_q <= ADDR; end
                            CmdWrite: begin op_q <= OP_WRITE; state_q <= ADDR; end
                            CmdExec:  begin op_q <= OP_EXEC;  state_q <= ADDR; end
                            default:  rx_ready_o <= ~eoc_set;
                        endcase
                    end else if (eoc_pend_q) begin
                        // Pending EOC goes out before the next command byte is accepted.
                        eoc_pend_q <= eoc_i;
                        rx_ready_o <= 1'b0;
                        tx_data_o  <= ByteEoc;
                        tx_valid_o <= 1'b1;
                        state_q    <= TX_RESP;
                    end else begin
                        rx_ready_o <= ~eoc_i;
                    end
                end

                ADDR: begin
                    if (rx_hs) begin
                        shift_q    <= shift_in;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            addr_q <= addr_in;
                            if (op_q == OP_EXEC) begin
                                exec_addr_o  <= addr_in;
                                exec_valid_o <= 1'b1;
                                rx_ready_o   <= 1'b0;
                                tx_data_o    <= ByteAck;
                                tx_valid_o   <= 1'b1;
                                state_q      <= TX_RESP;
                            end else begin
                                state_q <= LEN;
                            end
                        end
                    end
                end

                LEN: begin
                    if (rx_hs) begin
                        words_left_q <= (rx_data_i == 8'd0) ? 9'd256 : 9'(rx_data_i);
                        byte_cnt_q   <= 2'd0;
                        if (op_q == OP_READ) begin
                            rx_ready_o  <= 1'b0;
                            obi_req_o   <= 1'b1;
                            obi_addr_o  <= addr_q;
                            obi_we_o    <= 1'b0;
                            obi_wdata_o <= 32'd0;
                            state_q     <= BUS_REQ;
                        end else begin
                            state_q <= WDATA;
                        end
                    end
                end

                WDATA: begin
                    if (rx_hs) begin
                        shift_q    <= shift_in;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            rx_ready_o  <= 1'b0;
                            obi_req_o   <= 1'b1;
                            obi_addr_o  <= addr_q;
                            obi_we_o    <= 1'b1;
                            obi_wdata_o <= shift_in;
                            state_q     <= BUS_REQ;
                        end
                    end
                end

                BUS_REQ: begin
                    if (obi_gnt_i) begin
                        obi_req_o <= 1'b0;
                        state_q   <= BUS_WAIT;
                    end
                end

                BUS_WAIT: begin
                    if (obi_rvalid_i) begin
                        err_q        <= err_q | obi_err_i;
                        addr_q       <= addr_q + AddrWidth'(4);
                        words_left_q <= words_left_q - 9'd1;
                        byte_cnt_q   <= 2'd0;
                        if (op_q == OP_READ) begin
                            shift_q    <= obi_err_i ? 32'd0 : obi_rdata_i;
                            tx_data_o  <= obi_err_i ? 8'd0 : obi_rdata_i[7:0];
                            tx_valid_o <= 1'b1;
                            state_q    <= TX_DATA;
                        end else if (words_left_q == 9'd1) begin
                            tx_data_o  <= resp_byte(err_q | obi_err_i);
                            tx_valid_o <= 1'b1;
                            state_q    <= TX_RESP;
                        end else begin
                            rx_ready_o <= 1'b1;
                            state_q    <= WDATA;
                        end
                    end
                end

                TX_DATA: begin
                    if (tx_hs) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if (words_left_q == 9'd0) begin
                                tx_data_o <= resp_byte(err_q);
                                state_q   <= TX_RESP;
                            end else begin
                                tx_valid_o  <= 1'b0;
                                obi_req_o   <= 1'b1;
                                obi_addr_o  <= addr_q;
                                obi_we_o    <= 1'b0;
                                obi_wdata_o <= 32'd0;
                                state_q     <= BUS_REQ;
                            end
                        end else begin
                            shift_q   <= {8'h00, shift_q[31:8]};
                            tx_data_o <= shift_q[15:8];
                        end
                    end
                end

                TX_RESP: begin
                    if (tx_hs) begin
                        tx_valid_o <= 1'b0;
                        rx_ready_o <= ~eoc_set;
                        state_q    <= IDLE;
                    end
                end

                default: begin
                    rx_ready_o <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase

`ifdef UART_DBG_TIMEOUT_EN
            // Abandon a half-received command after a silent stretch on the link.
            if ((state_q == ADDR || state_q == LEN || state_q == WDATA) && !rx_hs) begin
                if (to_cnt_q == ToW'(TimeoutCycles - 1)) begin
                    to_cnt_q   <= '0;
                    rx_ready_o <= ~eoc_set;
                    state_q    <= IDLE;
                end else begin
                    to_cnt_q <= to_cnt_q + ToW'(1);
                end
            end else begin
                to_cnt_q <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_dbg_responder.sv
// Directed self-checking bench for uart_dbg_responder with a small OBI subordinate model.
module tb_uart_dbg_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;
    logic [31:0] exec_addr_o;
    logic        exec_valid_o;
    logic        eoc_i;

    uart_dbg_responder #(.TimeoutCycles(50), .AddrWidth(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
        .exec_addr_o(exec_addr_o), .exec_valid_o(exec_valid_o), .eoc_i(eoc_i)
    );

    always #5 clk_i = ~clk_i;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  tx_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] rd_addr_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int          exec_pulses = 0;
    logic [31:0] exec_seen = 32'd0;

    int          gnt_delay = 0;
    bit          rd_err    = 1'b0;
    bit          inject_rv = 1'b0;

    // OBI subordinate: grant after gnt_delay cycles of request, response the following cycle.
    initial begin
        int          wait_cnt;
        bit          rv_pend;
        logic [31:0] rv_data;
        bit          rv_err;
        logic [31:0] held_addr;
        logic [31:0] held_wdata;
        wait_cnt = 0; rv_pend = 0; rv_data = 0; rv_err = 0; held_addr = 0; held_wdata = 0;
        obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = 0; obi_err_i = 0;
        forever begin
            @(posedge clk_i); #1;
            obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = 0; obi_err_i = 0;
            if (!rst_ni) begin
                rv_pend = 0; wait_cnt = 0;
            end else begin
                if (rv_pend) begin
                    obi_rvalid_i = 1; obi_rdata_i = rv_data; obi_err_i = rv_err; rv_pend = 0;
                end else if (inject_rv) begin
                    obi_rvalid_i = 1; obi_rdata_i = 32'hCAFEF00D; inject_rv = 0;
                end
                if (obi_req_o) begin
                    if (wait_cnt == 0) begin
                        held_addr = obi_addr_o; held_wdata = obi_wdata_o;
                    end else begin
                        check("obi_hold", 64'({obi_addr_o, obi_wdata_o}), 64'({held_addr, held_wdata}));
                    end
                    if (wait_cnt >= gnt_delay) begin
                        obi_gnt_i = 1; wait_cnt = 0; rv_pend = 1; rv_err = rd_err;
                        if (obi_we_o) begin
                            wr_addr_log.push_back(obi_addr_o);
                            wr_data_log.push_back(obi_wdata_o);
                            rv_data = 32'd0;
                        end else begin
                            rd_addr_log.push_back(obi_addr_o);
                            rv_data = (rd_q.size() > 0) ? rd_q.pop_front() : 32'd0;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // Byte/exec monitor sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
            if (exec_valid_o) begin
                exec_pulses++;
                exec_seen = exec_addr_o;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_data_i = b; rx_valid_i = 1'b1;
        while (!rx_ready_o && guard < 2000) begin @(posedge clk_i); #1; guard++; end
        if (guard >= 2000) check("rx_accept_timeout", 64'(rx_ready_o), 64'd1);
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_vec(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
    endtask

    task automatic wait_tx(input int n, input int limit);
        int guard = 0;
        while (tx_q.size() < n && guard < limit) begin @(posedge clk_i); #1; guard++; end
        if (guard >= limit) check("tx_count_timeout", 64'(tx_q.size()), 64'(n));
    endtask

    task automatic check_tx(input string tag, input logic [127:0] v, input int n);
        check($sformatf("%s_len", tag), 64'(tx_q.size()), 64'(n));
        for (int i = 0; i < n && i < tx_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 64'(tx_q[i]), 64'(v[8*(n-1-i) +: 8]));
    endtask

    task automatic clear_logs();
        tx_q.delete(); rd_q.delete(); rd_addr_log.delete();
        wr_addr_log.delete(); wr_data_log.delete();
        exec_pulses = 0;
    endtask

    initial begin
        rst_ni = 0; rx_data_i = 0; rx_valid_i = 0; tx_ready_i = 1; eoc_i = 0;
        #12;
        check("rst_rx_ready", 64'(rx_ready_o), 64'd0);
        check("rst_tx", 64'({tx_valid_o, tx_data_o}), 64'd0);
        check("rst_obi", 64'({obi_req_o, obi_we_o, obi_be_o, obi_addr_o}), 64'd0);
        check("rst_exec", 64'({exec_valid_o, exec_addr_o}), 64'd0);
        @(posedge clk_i); #1; rst_ni = 1;
        cycles(3);
        check("idle_rx_ready", 64'(rx_ready_o), 64'd1);
        check("obi_be", 64'(obi_be_o), 64'hF);

        // Two-word write
        clear_logs();
        send_vec(128'({8'h12, 8'h00, 8'h00, 8'h00, 8'h10, 8'h02,
                       8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE}), 14);
        wait_tx(1, 300); cycles(3);
        check_tx("wr_resp", 128'(8'h06), 1);
        check("wr_count", 64'(wr_addr_log.size()), 64'd2);
        if (wr_addr_log.size() == 2) begin
            check("wr0", 64'({wr_addr_log[0], wr_data_log[0]}), 64'h10000000_12345678);
            check("wr1", 64'({wr_addr_log[1], wr_data_log[1]}), 64'h10000004_DEADBEEF);
        end

        // Single-word read
        clear_logs();
        rd_q.push_back(32'hDEADBEEF);
        send_vec(128'({8'h11, 8'h04, 8'h00, 8'h00, 8'h10, 8'h01}), 6);
        wait_tx(5, 300); cycles(3);
        check_tx("rd", 128'({8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h06}), 5);
        check("rd_count", 64'(rd_addr_log.size()), 64'd1);
        if (rd_addr_log.size() > 0) check("rd_addr", 64'(rd_addr_log[0]), 64'h10000004);

        // Read with bus error
        clear_logs();
        rd_err = 1; rd_q.push_back(32'h12345678);
        send_vec(128'({8'h11, 8'h00, 8'h00, 8'h00, 8'h20, 8'h01}), 6);
        wait_tx(5, 300); cycles(3);
        rd_err = 0;
        check_tx("rd_err", 128'({8'h00, 8'h00, 8'h00, 8'h00, 8'h15}), 5);

        // EXEC with two EOC pulses mid-command: one ACK then a single EOC
        clear_logs();
        send_vec(128'({8'h13, 8'h80, 8'h00, 8'h00}), 4);
        eoc_i = 1; cycles(1); eoc_i = 0; cycles(1); eoc_i = 1; cycles(1); eoc_i = 0;
        send_byte(8'h10);
        wait_tx(2, 300); cycles(6);
        check_tx("exec", 128'({8'h06, 8'h14}), 2);
        check("exec_pulses", 64'(exec_pulses), 64'd1);
        check("exec_addr", 64'(exec_seen), 64'h10000080);
        check("exec_no_bus", 64'(rd_addr_log.size() + wr_addr_log.size()), 64'd0);

        // Unknown bytes in IDLE are dropped silently
        clear_logs();
        send_byte(8'h55); send_byte(8'h00);
        cycles(10);
        check("junk_tx", 64'(tx_q.size()), 64'd0);
        check("junk_bus", 64'(rd_addr_log.size() + wr_addr_log.size()), 64'd0);

        // Two-word read with delayed grant and a 20-cycle transmitter stall
        clear_logs();
        gnt_delay = 5; tx_ready_i = 0;
        rd_q.push_back(32'h11223344); rd_q.push_back(32'h55667788);
        send_vec(128'({8'h11, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02}), 6);
        begin
            int guard = 0;
            while (!tx_valid_o && guard < 300) begin cycles(1); guard++; end
        end
        check("stall_first", 64'({tx_valid_o, tx_data_o}), 64'h144);
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            check("stall_hold", 64'({tx_valid_o, tx_data_o}), 64'h144);
        end
        tx_ready_i = 1;
        wait_tx(9, 500); cycles(3);
        gnt_delay = 0;
        check_tx("stall", 128'({8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h06}), 9);
        check("stall_rd_count", 64'(rd_addr_log.size()), 64'd2);
        if (rd_addr_log.size() == 2)
            check("stall_addrs", 64'({rd_addr_log[0], rd_addr_log[1]}), 64'h00000100_00000104);

        // Count 0 = 256 words, misaligned start, address wraps past the top
        clear_logs();
        send_vec(128'({8'h11, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h00}), 6);
        wait_tx(1025, 20000); cycles(3);
        check("c256_len", 64'(tx_q.size()), 64'd1025);
        if (tx_q.size() == 1025) check("c256_ack", 64'(tx_q[1024]), 64'h06);
        check("c256_rd_count", 64'(rd_addr_log.size()), 64'd256);
        if (rd_addr_log.size() == 256) begin
            check("c256_first", 64'(rd_addr_log[0]), 64'hFFFFFF00);
            check("c256_wrap", 64'(rd_addr_log[64]), 64'h00000000);
            check("c256_last", 64'(rd_addr_log[255]), 64'h000002FC);
        end

        // Reset while a request is waiting for grant; late rvalid ignored afterwards
        clear_logs();
        gnt_delay = 50;
        send_vec(128'({8'h11, 8'h00, 8'h00, 8'h00, 8'h30, 8'h01}), 6);
        begin
            int guard = 0;
            while (!obi_req_o && guard < 50) begin cycles(1); guard++; end
        end
        check("pre_rst_req", 64'(obi_req_o), 64'd1);
        rst_ni = 0; #2;
        check("mid_rst_outs", 64'({obi_req_o, rx_ready_o, tx_valid_o, exec_valid_o}), 64'd0);
        cycles(2); rst_ni = 1; gnt_delay = 0;
        cycles(2); inject_rv = 1;
        cycles(10);
        check("late_rv_tx", 64'(tx_q.size()), 64'd0);
        check("late_rv_idle", 64'({obi_req_o, rx_ready_o}), 64'b01);
        rd_q.push_back(32'h0A0B0C0D);
        send_vec(128'({8'h11, 8'h08, 8'h00, 8'h00, 8'h00, 8'h01}), 6);
        wait_tx(5, 300); cycles(3);
        check_tx("post_rst", 128'({8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h06}), 5);
        if (rd_addr_log.size() > 0) check("post_rst_addr", 64'(rd_addr_log[rd_addr_log.size()-1]), 64'h8);

`ifdef UART_DBG_TIMEOUT_EN
        clear_logs();
        send_vec(128'({8'h11, 8'h00}), 2);
        cycles(60);
        check("to_tx", 64'(tx_q.size()), 64'd0);
        check("to_idle", 64'({obi_req_o, rx_ready_o}), 64'b01);
        rd_q.push_back(32'h01020304);
        send_vec(128'({8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}), 6);
        wait_tx(5, 300); cycles(3);
        check_tx("to_next", 128'({8'h04, 8'h03, 8'h02, 8'h01, 8'h06}), 5);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
